// File: rtl/icdir_ctl.sv
// I-cache directory client: tag lookup with 1-cycle hit/miss response, reload/invalidate
// writes, and a line-by-line invalidate-all walk at reset and on request.
module icdir_ctl #(
  parameter int unsigned LINES = 128,
  parameter int unsigned TAG_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  input  logic [33:0]      req_adr,
  output logic             req_rdy,
  output logic             rsp_val,
  output logic             rsp_hit,
  output logic [6:0]       rsp_idx,
  input  logic             wr_val,
  input  logic             wr_inv,
  input  logic [33:0]      wr_adr,
  output logic             wr_rdy,
  input  logic             flush,
  output logic             flush_busy,
  output logic             flush_done,
  output logic [6:0]       dir_rd_adr,
  input  logic [TAG_W:0]   dir_rd_dat,
  output logic [3:0]       dir_wr_en,
  output logic [6:0]       dir_wr_adr,
  output logic [TAG_W:0]   dir_wr_dat
);

  localparam int unsigned ADR_W   = 34;
  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned IDX_LSB = 6;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } dir_entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rsp_val_q, rsp_val_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [TAG_W-1:0]   wr_tag;
  dir_entry_t         rd_ent;
  dir_entry_t         wr_ent;
  logic               lookup_hit;
  logic               unused_adr_bits;

  assign rd_idx     = req_adr[IDX_LSB +: IDX_W];
  assign wr_idx     = wr_adr[IDX_LSB +: IDX_W];
  assign rd_tag     = req_adr[ADR_W-1 -: TAG_W];
  assign wr_tag     = wr_adr[ADR_W-1 -: TAG_W];
  assign rd_ent     = dir_rd_dat;
  assign lookup_hit = rd_ent.valid && (rd_ent.tag == rd_tag);
  assign wr_ent     = wr_inv ? '0 : dir_entry_t'{valid: 1'b1, tag: wr_tag};

  // Offset bits and (for small LINES) upper index bits are intentionally ignored.
  assign unused_adr_bits = ^{req_adr, wr_adr};

  // Read port always follows the lookup index; only sampled on an accepted lookup.
  assign dir_rd_adr = 7'(rd_idx);

  assign flush_busy = (state_q == S_FLUSH);
  assign flush_done = done_q;
  assign rsp_val    = rsp_val_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_idx    = 7'(rsp_idx_q);

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FLUSH;
      cnt_q     <= '0;
      rsp_val_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_val_q <= rsp_val_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_idx_q <= rsp_idx_d;
      done_q    <= done_d;
    end
  end

  // Next-state, handshakes and directory write port. Outputs are held quiet while rst is high.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_val_d  = 1'b0;
    rsp_hit_d  = rsp_hit_q;
    rsp_idx_d  = rsp_idx_q;
    done_d     = 1'b0;
    req_rdy    = 1'b0;
    wr_rdy     = 1'b0;
    dir_wr_en  = 4'b0000;
    dir_wr_adr = 7'd0;
    dir_wr_dat = '0;

    if (!rst) begin
      case (state_q)
        S_FLUSH: begin
          dir_wr_en  = 4'b1111;
          dir_wr_adr = 7'(cnt_q);
          cnt_d      = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(LINES - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        S_IDLE: begin
          if (flush) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            wr_rdy  = 1'b1;
            req_rdy = ~wr_val;
            // A write owns the cycle, so a lookup never races a write to the same line.
            if (wr_val) begin
              dir_wr_en  = 4'b1111;
              dir_wr_adr = 7'(wr_idx);
              dir_wr_dat = wr_ent;
            end else if (req_val) begin
              rsp_val_d = 1'b1;
              rsp_hit_d = lookup_hit;
              rsp_idx_d = rd_idx;
            end
          end
        end
        default: begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icdir_ctl.sv
// Bench for icdir_ctl: directory storage model plus a per-line valid/tag reference checked every cycle.
module tb_icdir_ctl;

  localparam int LINES = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [33:0] req_adr;
  logic        req_rdy;
  logic        rsp_val;
  logic        rsp_hit;
  logic [6:0]  rsp_idx;
  logic        wr_val;
  logic        wr_inv;
  logic [33:0] wr_adr;
  logic        wr_rdy;
  logic        flush;
  logic        flush_busy;
  logic        flush_done;
  logic [6:0]  dir_rd_adr;
  logic [21:0] dir_rd_dat;
  logic [3:0]  dir_wr_en;
  logic [6:0]  dir_wr_adr;
  logic [21:0] dir_wr_dat;

  always #5 clk = ~clk;

  icdir_ctl #(.LINES(LINES), .TAG_W(21)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_adr(req_adr), .req_rdy(req_rdy),
    .rsp_val(rsp_val), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .wr_val(wr_val), .wr_inv(wr_inv), .wr_adr(wr_adr), .wr_rdy(wr_rdy),
    .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done),
    .dir_rd_adr(dir_rd_adr), .dir_rd_dat(dir_rd_dat),
    .dir_wr_en(dir_wr_en), .dir_wr_adr(dir_wr_adr), .dir_wr_dat(dir_wr_dat)
  );

  // Directory storage: combinational read, write at the clock edge.
  logic [21:0] dir_mem [LINES];
  always @(posedge clk) if (dir_wr_en == 4'hF) dir_mem[dir_wr_adr] <= dir_wr_dat;
  assign dir_rd_dat = dir_mem[dir_rd_adr];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: what each directory line should hold, plus expected flush/response timing.
  bit        ref_v   [LINES];
  bit [20:0] ref_tag [LINES];
  bit        m_busy, m_done, m_rv, m_rh;
  int        m_cnt, m_ri;

  // One clock cycle: inputs were set at the falling edge by the caller.
  task automatic cycle();
    bit          e_wrdy, e_rrdy, e_we;
    int          e_wadr, idx;
    logic [21:0] e_wdat;
    bit          n_busy, n_done, n_rv, n_rh;
    int          n_cnt, n_ri;
    #1;
    if (rst) begin
      m_busy = 1; m_cnt = 0; m_done = 0; m_rv = 0; m_rh = 0; m_ri = 0;
    end
    check("flush_busy", flush_busy, m_busy);
    check("flush_done", flush_done, m_done);
    check("rsp_val", rsp_val, m_rv);
    if (m_rv || rst) begin
      check("rsp_hit", rsp_hit, m_rh);
      check("rsp_idx", rsp_idx, m_ri);
    end
    if (flush_done === 1'b1) done_cnt++;

    e_wrdy = 0; e_rrdy = 0; e_we = 0; e_wadr = 0; e_wdat = '0;
    n_busy = m_busy; n_cnt = m_cnt; n_done = 0; n_rv = 0; n_rh = m_rh; n_ri = m_ri;
    if (rst) begin
      n_busy = 1;
    end else if (m_busy) begin
      e_we = 1; e_wadr = m_cnt; e_wdat = '0;
      ref_v[m_cnt] = 0;
      n_cnt = m_cnt + 1;
      if (m_cnt == LINES - 1) begin
        n_busy = 0; n_done = 1; n_cnt = 0;
      end
    end else if (flush) begin
      n_busy = 1; n_cnt = 0;
    end else begin
      e_wrdy = 1;
      e_rrdy = !wr_val;
      if (wr_val) begin
        idx = int'(wr_adr[12:6]);
        e_we = 1; e_wadr = idx;
        e_wdat = wr_inv ? 22'd0 : {1'b1, wr_adr[33:13]};
        ref_v[idx] = !wr_inv;
        ref_tag[idx] = wr_adr[33:13];
      end else if (req_val) begin
        idx = int'(req_adr[12:6]);
        n_rv = 1; n_ri = idx;
        n_rh = ref_v[idx] && (ref_tag[idx] == req_adr[33:13]);
      end
    end
    check("wr_rdy", wr_rdy, e_wrdy);
    check("req_rdy", req_rdy, e_rrdy);
    check("dir_wr_en", dir_wr_en, e_we ? 4'hF : 4'h0);
    if (e_we) begin
      check("dir_wr_adr", dir_wr_adr, e_wadr);
      check("dir_wr_dat", dir_wr_dat, e_wdat);
    end
    @(posedge clk);
    if (!rst) begin
      m_busy = n_busy; m_cnt = n_cnt; m_done = n_done; m_rv = n_rv; m_rh = n_rh; m_ri = n_ri;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    req_val = 0; wr_val = 0; wr_inv = 0; flush = 0;
  endtask

  task automatic run(input int n);
    quiet();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_wr(input logic [33:0] a, input logic inv);
    quiet(); wr_val = 1; wr_inv = inv; wr_adr = a;
    cycle();
    quiet();
  endtask

  task automatic do_rd(input logic [33:0] a);
    quiet(); req_val = 1; req_adr = a;
    cycle();
    quiet();
  endtask

  function automatic logic [33:0] mk(input int tag, input int idx);
    logic [5:0] off;
    off = 6'($urandom);
    return {21'(tag), 7'(idx), off};
  endfunction

  initial begin
    rst = 1; req_adr = '0; wr_adr = '0;
    quiet();
    @(negedge clk);
    cycle();
    cycle();
    check("reset_dir_wr_en", dir_wr_en, 4'h0);

    // Power-up walk: 128 writes, then one flush_done pulse.
    rst = 0;
    run(LINES + 1);
    check("init_done_pulses", done_cnt, 1);
    check("init_idle_rdy", req_rdy, 1);

    // Reload then look up the same line.
    do_wr(34'h0_0000_2040, 0);
    do_rd(34'h0_0000_2040);
    check("tp2_rsp_val", rsp_val, 1);
    check("tp2_hit", rsp_hit, 1);
    check("tp2_idx", rsp_idx, 1);
    do_rd(34'h0_0000_4040);
    check("tp3_tag_miss", rsp_hit, 0);
    do_wr(34'h0_0000_2040, 1);
    do_rd(34'h0_0000_2040);
    check("tp3_inv_miss", rsp_hit, 0);

    // Simultaneous write and lookup: write wins, lookup goes next cycle.
    quiet(); wr_val = 1; wr_adr = 34'h0_0000_8080; req_val = 1; req_adr = 34'h0_0000_8080;
    cycle();
    check("tp4_rsp_blocked", rsp_val, 0);
    wr_val = 0;
    cycle();
    quiet();
    check("tp4_hit", rsp_hit, 1);
    check("tp4_idx", rsp_idx, 2);

    // Flush with three valid lines; a second flush mid-walk is ignored.
    do_wr(mk(5, 3), 0);
    do_wr(mk(6, 4), 0);
    do_wr(mk(7, 5), 0);
    done_cnt = 0;
    quiet(); flush = 1; cycle();
    run(20);
    flush = 1; cycle();
    run(LINES + 2 - 21);
    check("tp5_done_pulses", done_cnt, 1);
    do_rd(mk(5, 3)); check("tp5_miss3", rsp_hit, 0);
    do_rd(mk(6, 4)); check("tp5_miss4", rsp_hit, 0);
    do_rd(mk(7, 5)); check("tp5_miss5", rsp_hit, 0);

    // Random mixed traffic over a small address pool.
    for (int i = 0; i < 800; i++) begin
      quiet();
      wr_val  = ($urandom % 4) == 0;
      wr_inv  = ($urandom % 3) == 0;
      wr_adr  = mk(1 + int'($urandom % 3), int'($urandom % 8));
      req_val = ($urandom % 3) != 0;
      req_adr = mk(1 + int'($urandom % 3), int'($urandom % 8));
      flush   = ($urandom % 250) == 0;
      cycle();
    end

    // Reset at walk cycle 50: async return to reset state, walk restarts at 0.
    run(LINES + 2);
    do_wr(mk(9, 7), 0);
    quiet(); flush = 1; cycle();
    run(50);
    rst = 1;
    cycle();
    check("tp6_async_busy", flush_busy, 1);
    check("tp6_async_wr_en", dir_wr_en, 4'h0);
    check("tp6_async_req_rdy", req_rdy, 0);
    rst = 0;
    #1;
    check("tp6_restart_adr", dir_wr_adr, 0);
    #1;
    @(negedge clk);
    // The partial cycle above already handled the edge; continue aligned on falling edges.
    m_busy = 1; m_cnt = 1;
    run(LINES + 1);
    do_rd(mk(9, 7)); check("tp6_post_miss", rsp_hit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
